// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a req/ack data memory and stalling upstream
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_start,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rd_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] instr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        err_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]  r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        w_access, w_we, w_legal, w_misal, w_go, w_unused;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_f3     = instr_i[14:12];
  assign w_off    = alu_result_i[1:0];
  assign w_access = mem_read_i | mem_write_i;
  assign w_we     = mem_write_i;
  assign w_unused = ^{instr_i[31:15], instr_i[11:0]};
  // decode the presented access and extract the acked load lane
  always_comb begin
    w_legal = w_we ? (~w_f3[2] & (w_f3[1:0] != 2'b11)) : ((w_f3[1:0] != 2'b11) & ~(w_f3[2] & w_f3[1]));
    w_misal = ((w_f3[1:0] == 2'b01) & w_off[0]) | ((w_f3[1:0] == 2'b10) & (|w_off));
    w_go    = w_access & w_legal & ~w_misal;
    w_be    = !w_we ? 4'hF : (w_f3[1:0] == 2'b00) ? 4'b0001 << w_off :
              (w_f3[1:0] == 2'b01) ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'hF;
    w_wdata = (w_f3[1:0] == 2'b00) ? {4{rd_data_i[7:0]}} :
              (w_f3[1:0] == 2'b01) ? {2{rd_data_i[15:0]}} : rd_data_i;
    w_byte  = dmem_rdata_i[{r_off, 3'b000} +: 8];
    w_half  = r_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    w_ext   = (r_f3[1:0] == 2'b00) ? {{24{~r_f3[2] & w_byte[7]}}, w_byte} :
              (r_f3[1:0] == 2'b01) ? {{16{~r_f3[2] & w_half[15]}}, w_half} : dmem_rdata_i;
    stall_o = ((r_state == S_IDLE) & w_go) | (r_state == S_BUSY);
  end
  // transaction FSM: issue, wait for ack or timeout, one settle cycle
  always_ff @(posedge sys_clk) begin
    if (!sys_start) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_f3         <= '0;
      r_off        <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      err_o        <= 1'b0;
      case (r_state)
        S_IDLE: if (w_access) begin
          if (w_go) begin
            r_state      <= S_BUSY;
            r_cnt        <= '0;
            r_f3         <= w_f3;
            r_off        <= w_off;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= w_we;
            dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
            dmem_be_o    <= w_be;
            dmem_wdata_o <= w_wdata;
          end else begin
            err_o <= 1'b1;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 32'd1;
          if (dmem_ack_i) begin
            r_state    <= S_DONE;
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) begin
              load_data_o  <= w_ext;
              load_valid_o <= 1'b1;
            end
          end else if (TIMEOUT != 0 && r_cnt == TIMEOUT - 1) begin
            r_state    <= S_DONE;
            dmem_req_o <= 1'b0;
            err_o      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed LSU stimulus checked each cycle against a transaction-level model
module tb_mem_stage_lsu;
  localparam int TO = 8;
  logic        sys_clk = 1'b0, sys_start = 1'b0;
  logic [31:0] alu_result_i = '0, rd_data_i = '0, instr_i = '0, dmem_rdata_i = '0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0, dmem_ack_i = 1'b0;
  logic        dmem_req_o, dmem_we_o, stall_o, load_valid_o, err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, load_data_o;
  logic [3:0]  dmem_be_o;
  int n_chk = 0, n_err = 0;
  int stall_cnt = 0, lv_cnt = 0, err_cnt = 0, req_cnt = 0;
  bit run = 1'b0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;
  logic        m_busy, m_done, m_req, m_we, m_lv, m_err, m_wdk;
  logic [31:0] m_addr, m_wd, m_ld;
  logic [3:0]  m_be;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  int          m_n;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_start(sys_start), .alu_result_i(alu_result_i), .rd_data_i(rd_data_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .instr_i(instr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .load_data_o(load_data_o), .load_valid_o(load_valid_o), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ok(input bit we, input logic [2:0] f3, input logic [1:0] off);
    bit legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return legal && (int'(off) % nbytes(f3) == 0);
  endfunction

  function automatic logic [3:0] be_of(input bit we, input logic [2:0] f3, input logic [1:0] off);
    return we ? 4'(((1 << nbytes(f3)) - 1) << off) : 4'hF;
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] f3, input logic [31:0] d);
    int nb = nbytes(f3);
    return nb == 1 ? {24'h0, d[7:0]} * 32'h01010101 : nb == 2 ? {16'h0, d[15:0]} * 32'h00010001 : d;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] r);
    logic [31:0] v = r >> (8 * off);
    int nb = nbytes(f3);
    if (nb == 1) begin
      v &= 32'hFF;
      if (f3 < 3'd4 && v[7]) v |= 32'hFFFFFF00;
    end else if (nb == 2) begin
      v &= 32'hFFFF;
      if (f3 < 3'd4 && v[15]) v |= 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // transaction-level model: one outstanding access, ack or timeout, one idle-settle cycle
  always @(posedge sys_clk) begin
    m_lv  <= 1'b0;
    m_err <= 1'b0;
    if (!sys_start) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_addr <= '0;
      m_be <= '0; m_wd <= '0; m_wdk <= 1'b1; m_ld <= '0; m_f3 <= '0; m_off <= '0; m_n <= 0;
    end else if (m_busy) begin
      m_n <= m_n + 1;
      if (dmem_ack_i) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_req <= 1'b0;
        if (!m_we) begin
          m_ld <= extract(m_f3, m_off, dmem_rdata_i);
          m_lv <= 1'b1;
        end
      end else if (m_n + 1 == TO) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_req <= 1'b0; m_err <= 1'b1;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (mem_read_i | mem_write_i) begin
      if (ok(mem_write_i, instr_i[14:12], alu_result_i[1:0])) begin
        m_busy <= 1'b1; m_n <= 0; m_req <= 1'b1; m_we <= mem_write_i;
        m_addr <= alu_result_i & 32'hFFFFFFFC; m_off <= alu_result_i[1:0]; m_f3 <= instr_i[14:12];
        m_be <= be_of(mem_write_i, instr_i[14:12], alu_result_i[1:0]);
        m_wd <= wd_of(instr_i[14:12], rd_data_i); m_wdk <= mem_write_i;
      end else begin
        m_err <= 1'b1;
      end
    end
  end

  // per-cycle comparison against the model, mid-cycle
  always @(negedge sys_clk) begin
    if (run) begin
      chk("stall", 32'(stall_o), 32'(m_busy | (!m_done && (mem_read_i | mem_write_i) &&
          ok(mem_write_i, instr_i[14:12], alu_result_i[1:0]))));
      chk("req", 32'(dmem_req_o), 32'(m_req));
      chk("we", 32'(dmem_we_o), 32'(m_we));
      chk("addr", dmem_addr_o, m_addr);
      chk("be", 32'(dmem_be_o), 32'(m_be));
      if (m_wdk) chk("wdata", dmem_wdata_o, m_wd);
      chk("load_valid", 32'(load_valid_o), 32'(m_lv));
      chk("load_data", load_data_o, m_ld);
      chk("err", 32'(err_o), 32'(m_err));
      chk("lv_err_excl", 32'(load_valid_o & err_o), 32'd0);
      stall_cnt += int'(stall_o);
      lv_cnt    += int'(load_valid_o);
      err_cnt   += int'(err_o);
      req_cnt   += int'(dmem_req_o);
    end
  end

  task automatic present(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    mem_read_i = rd; mem_write_i = wr; instr_i = 32'h00000003 | (32'(f3) << 12);
    alu_result_i = a; rd_data_i = d;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input int k, input bit do_ack, input logic [31:0] rdat);
    present(rd, wr, f3, a, d);
    stall_cnt = 0; lv_cnt = 0; err_cnt = 0;
    for (int i = 0; i < k; i++) begin
      @(posedge sys_clk); #1;
      if (i == 0) begin
        cap_we = dmem_we_o; cap_addr = dmem_addr_o; cap_be = dmem_be_o; cap_wd = dmem_wdata_o;
      end
    end
    if (do_ack) begin dmem_ack_i = 1'b1; dmem_rdata_i = rdat; end
    @(posedge sys_clk); #1;
    dmem_ack_i = !do_ack; dmem_rdata_i = ~rdat;
    @(posedge sys_clk); #1;
    dmem_ack_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  task automatic bad(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    present(rd, wr, f3, a, 32'hCAFEF00D);
    stall_cnt = 0; err_cnt = 0; req_cnt = 0;
    @(posedge sys_clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(posedge sys_clk); #1;
    chk("bad_err_pulses", 32'(err_cnt), 32'd1);
    chk("bad_stall", 32'(stall_cnt), 32'd0);
    chk("bad_req", 32'(req_cnt), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    #1; sys_start = 1'b1; run = 1'b1;
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_load_data", load_data_o, 32'd0);
    @(posedge sys_clk); #1;
    txn(1, 0, 3'b010, 32'h104, 0, 3, 1, 32'hDEADBEEF);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lw_data", load_data_o, 32'hDEADBEEF);
    chk("lw_valid_pulses", 32'(lv_cnt), 32'd1);
    chk("lw_addr", cap_addr, 32'h104);
    chk("lw_be", 32'(cap_be), 32'hF);
    txn(1, 0, 3'b000, 32'h103, 0, 1, 1, 32'h80F17F80);
    chk("lb3", load_data_o, 32'hFFFFFF80);
    chk("min_stall", 32'(stall_cnt), 32'd2);
    txn(1, 0, 3'b100, 32'h102, 0, 2, 1, 32'h80F17F80);
    chk("lbu2", load_data_o, 32'h000000F1);
    txn(1, 0, 3'b000, 32'h101, 0, 1, 1, 32'h80F17F80);
    chk("lb1", load_data_o, 32'h0000007F);
    txn(1, 0, 3'b001, 32'h102, 0, 1, 1, 32'h80F17F80);
    chk("lh2", load_data_o, 32'hFFFF80F1);
    txn(1, 0, 3'b101, 32'h100, 0, 1, 1, 32'h80F17F80);
    chk("lhu0", load_data_o, 32'h00007F80);
    txn(1, 0, 3'b101, 32'h102, 0, 1, 1, 32'h80F17F80);
    chk("lhu2", load_data_o, 32'h000080F1);
    txn(0, 1, 3'b000, 32'h203, 32'h12345678, 2, 1, 32'h0);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wd, 32'h78787878);
    chk("sb_we", 32'(cap_we), 32'd1);
    chk("sb_addr", cap_addr, 32'h200);
    chk("sb_no_valid", 32'(lv_cnt), 32'd0);
    chk("sb_load_held", load_data_o, 32'h000080F1);
    txn(0, 1, 3'b001, 32'h202, 32'h12345678, 1, 1, 32'h0);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wd, 32'h56785678);
    txn(0, 1, 3'b010, 32'h208, 32'hA5A5_0F0F, 1, 1, 32'h0);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_wdata", cap_wd, 32'hA5A50F0F);
    txn(1, 1, 3'b000, 32'h401, 32'h000000AB, 1, 1, 32'h0);
    chk("both_store_wins", 32'(cap_we), 32'd1);
    chk("both_be", 32'(cap_be), 32'h2);
    bad(1, 0, 3'b010, 32'h102);
    bad(0, 1, 3'b001, 32'h101);
    bad(1, 0, 3'b011, 32'h100);
    bad(0, 1, 3'b100, 32'h100);
    txn(1, 0, 3'b010, 32'h300, 0, TO, 0, 32'h11111111);
    chk("to_err_pulses", 32'(err_cnt), 32'd1);
    chk("to_stall_cycles", 32'(stall_cnt), 32'(TO + 1));
    chk("to_no_valid", 32'(lv_cnt), 32'd0);
    chk("to_load_held", load_data_o, 32'h000080F1);
    present(1, 0, 3'b010, 32'h500, 0);
    @(posedge sys_clk); #1;
    sys_start = 1'b0; mem_read_i = 1'b0;
    @(posedge sys_clk); #1;
    sys_start = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h87654321; lv_cnt = 0;
    chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_addr", dmem_addr_o, 32'd0);
    chk("mid_rst_be", 32'(dmem_be_o), 32'd0);
    chk("mid_rst_load_data", load_data_o, 32'd0);
    @(posedge sys_clk); #1;
    dmem_ack_i = 1'b0;
    @(posedge sys_clk); #1;
    chk("late_ack_no_valid", 32'(lv_cnt), 32'd0);
    txn(1, 0, 3'b000, 32'h600, 0, 1, 1, 32'h000000FE);
    chk("after_rst_lb0", load_data_o, 32'hFFFFFFFE);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
